// File: rtl/tlb_op_pkg.sv
// Shared definitions for the TLB maintenance-op sequencer: op codes, INVTLB sub-ops,
// FSM state encoding and default widths.
package tlb_op_pkg;

  localparam int unsigned TLB_IDXBITS_DEF = 4;
  localparam int unsigned GRLEN_DEF       = 32;

  localparam logic [2:0] TLBOP_SRCH = 3'd0;
  localparam logic [2:0] TLBOP_RD   = 3'd1;
  localparam logic [2:0] TLBOP_WR   = 3'd2;
  localparam logic [2:0] TLBOP_FILL = 3'd3;
  localparam logic [2:0] TLBOP_INV  = 3'd4;

  localparam logic [4:0] INV_ALL        = 5'd0;
  localparam logic [4:0] INV_ALL1       = 5'd1;
  localparam logic [4:0] INV_G          = 5'd2;
  localparam logic [4:0] INV_NG         = 5'd3;
  localparam logic [4:0] INV_NG_ASID    = 5'd4;
  localparam logic [4:0] INV_NG_ASID_VA = 5'd5;
  localparam logic [4:0] INV_G_ASID_VA  = 5'd6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_ISSUE,
    ST_WAIT,
    ST_DONE,
    ST_WALK
  } state_t;

endpackage

// File: rtl/tlb_op_sequencer_dport_mux.sv
// Data-search port arbiter: forwards LSU lookups unless blocked, gives TLBSRCH the port
// during its issue cycle, and tracks whether a forwarded LSU lookup is still outstanding.
module tlb_dport_mux
  import tlb_op_pkg::*;
#(
  parameter int unsigned GRLEN = GRLEN_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_lsu_req,
  input  logic             i_lsu_wr,
  input  logic [GRLEN-1:0] i_lsu_vaddr,
  input  logic             i_lsu_block,
  input  logic             i_srch_req,
  input  logic [GRLEN-1:0] i_srch_vaddr,
  input  logic             i_dp_finish,
  output logic             o_lsu_gnt,
  output logic             o_dp_req,
  output logic             o_dp_wr,
  output logic [GRLEN-1:0] o_dp_vaddr,
  output logic             o_lsu_pend
);

  logic w_gnt;
  logic r_lsu_pend;

  assign w_gnt      = i_lsu_req & ~i_lsu_block & ~i_srch_req;
  assign o_lsu_gnt  = w_gnt;
  assign o_dp_req   = w_gnt | i_srch_req;
  assign o_dp_wr    = i_srch_req ? 1'b0 : i_lsu_wr;
  assign o_dp_vaddr = i_srch_req ? i_srch_vaddr : i_lsu_vaddr;
  assign o_lsu_pend = r_lsu_pend;

  // A new grant in the same cycle as a completion leaves a lookup outstanding.
  always_ff @(posedge clk) begin
    if (reset)            r_lsu_pend <= 1'b0;
    else if (w_gnt)       r_lsu_pend <= 1'b1;
    else if (i_dp_finish) r_lsu_pend <= 1'b0;
  end

endmodule

// File: rtl/tlb_op_sequencer.sv
// Sequences TLB maintenance ops from EX onto the TLB and shares the data-search port with
// the LSU. Define TLB_INV_WALK_EN to run INVTLB as a per-entry walk instead of one request.
module tlb_op_sequencer
  import tlb_op_pkg::*;
#(
  parameter int unsigned IDXBITS = TLB_IDXBITS_DEF,
  parameter int unsigned GRLEN   = GRLEN_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               ex_req,
  input  logic [2:0]         ex_op,
  input  logic [4:0]         ex_inv_op,
  input  logic [9:0]         ex_inv_asid,
  input  logic [GRLEN-1:0]   ex_inv_va,
  input  logic               ex_flush,
  output logic               ex_recv,
  output logic               ex_done,
  input  logic               lsu_req,
  input  logic               lsu_wr,
  input  logic [GRLEN-1:0]   lsu_vaddr,
  output logic               lsu_gnt,
  output logic               dp_req,
  output logic               dp_wr,
  output logic [GRLEN-1:0]   dp_vaddr,
  input  logic               dp_finish,
  output logic               t_req,
  output logic [2:0]         t_op,
  output logic [IDXBITS-1:0] t_idx,
  output logic [4:0]         t_inv_op,
  output logic [9:0]         t_inv_asid,
  output logic [GRLEN-1:0]   t_inv_va,
  input  logic               t_finish
);

  state_t             r_state, w_state_nxt;
  logic [2:0]         r_op;
  logic [4:0]         r_inv_op;
  logic [9:0]         r_inv_asid;
  logic [GRLEN-1:0]   r_inv_va;
  logic [IDXBITS-1:0] r_rnd, r_rnd_lat;
  logic               r_tfin, r_dpfin;
  logic               w_tfin_nxt, w_dpfin_nxt;
  logic               w_got_t, w_got_dp;
  logic               w_accept, w_treq, w_done;
  logic [IDXBITS-1:0] w_idx;
  logic               w_lsu_pend, w_lsu_block, w_srch_req;
`ifdef TLB_INV_WALK_EN
  logic [IDXBITS-1:0] r_walk_idx, w_walk_idx_nxt;
  logic               r_walk_busy, w_walk_busy_nxt;
`endif

  tlb_dport_mux #(.GRLEN(GRLEN)) u_dport_mux (
    .clk          (clk),
    .reset        (reset),
    .i_lsu_req    (lsu_req),
    .i_lsu_wr     (lsu_wr),
    .i_lsu_vaddr  (lsu_vaddr),
    .i_lsu_block  (w_lsu_block),
    .i_srch_req   (w_srch_req),
    .i_srch_vaddr (r_inv_va),
    .i_dp_finish  (dp_finish),
    .o_lsu_gnt    (lsu_gnt),
    .o_dp_req     (dp_req),
    .o_dp_wr      (dp_wr),
    .o_dp_vaddr   (dp_vaddr),
    .o_lsu_pend   (w_lsu_pend)
  );

  assign w_lsu_block = (r_state != ST_IDLE) | w_accept | reset;
  assign w_srch_req  = (r_state == ST_ISSUE) & (r_op == TLBOP_SRCH) & ~reset;

  assign ex_recv    = w_accept & ~reset;
  assign ex_done    = w_done & ~reset;
  assign t_req      = w_treq & ~reset;
  assign t_op       = r_op;
  assign t_idx      = w_idx;
  assign t_inv_op   = r_inv_op;
  assign t_inv_asid = r_inv_asid;
  assign t_inv_va   = r_inv_va;

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_treq      = 1'b0;
    w_done      = 1'b0;
    w_tfin_nxt  = r_tfin;
    w_dpfin_nxt = r_dpfin;
    w_got_t     = r_tfin | t_finish;
    w_got_dp    = (r_op != TLBOP_SRCH) | r_dpfin | dp_finish;
    w_idx       = (r_op == TLBOP_FILL) ? r_rnd_lat : '0;
`ifdef TLB_INV_WALK_EN
    w_walk_idx_nxt  = r_walk_idx;
    w_walk_busy_nxt = r_walk_busy;
`endif
    case (r_state)
      ST_IDLE: begin
        w_accept = ex_req & ~ex_flush;
        if (w_accept) begin
          w_state_nxt = ST_DRAIN;
          w_tfin_nxt  = 1'b0;
          w_dpfin_nxt = 1'b0;
        end
      end
      ST_DRAIN: begin
        if (ex_flush) w_state_nxt = ST_IDLE;
        else if (!w_lsu_pend) begin
          w_state_nxt = ST_ISSUE;
`ifdef TLB_INV_WALK_EN
          if (r_op == TLBOP_INV) begin
            w_state_nxt     = ST_WALK;
            w_walk_idx_nxt  = '0;
            w_walk_busy_nxt = 1'b0;
          end
`endif
        end
      end
      // TLBSRCH completes only once both the TLB and the data-search port have finished.
      ST_ISSUE, ST_WAIT: begin
        w_treq = (r_state == ST_ISSUE);
        if (w_got_t && w_got_dp) w_state_nxt = ST_DONE;
        else begin
          w_state_nxt = ST_WAIT;
          w_tfin_nxt  = w_got_t;
          w_dpfin_nxt = w_got_dp;
        end
      end
      ST_DONE: begin
        w_done      = 1'b1;
        w_state_nxt = ST_IDLE;
      end
`ifdef TLB_INV_WALK_EN
      ST_WALK: begin
        w_idx  = r_walk_idx;
        w_treq = ~r_walk_busy;
        if (t_finish) begin
          w_walk_busy_nxt = 1'b0;
          if (r_walk_idx == '1) begin
            w_walk_idx_nxt = '0;
            w_state_nxt    = ST_DONE;
          end else begin
            w_walk_idx_nxt = r_walk_idx + 1'b1;
          end
        end else begin
          w_walk_busy_nxt = 1'b1;
        end
      end
`endif
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_rnd <= '0;
    else       r_rnd <= r_rnd + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_op       <= '0;
      r_inv_op   <= '0;
      r_inv_asid <= '0;
      r_inv_va   <= '0;
      r_rnd_lat  <= '0;
      r_tfin     <= 1'b0;
      r_dpfin    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_tfin  <= w_tfin_nxt;
      r_dpfin <= w_dpfin_nxt;
      if (w_accept) begin
        r_op       <= ex_op;
        r_inv_op   <= ex_inv_op;
        r_inv_asid <= ex_inv_asid;
        r_inv_va   <= ex_inv_va;
        r_rnd_lat  <= r_rnd;
      end
    end
  end

`ifdef TLB_INV_WALK_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      r_walk_idx  <= '0;
      r_walk_busy <= 1'b0;
    end else begin
      r_walk_idx  <= w_walk_idx_nxt;
      r_walk_busy <= w_walk_busy_nxt;
    end
  end
`endif

endmodule
